// File: rtl/core_req_arbiter.sv
// core_req_arbiter: shares one core-side req/gnt/rvalid port between two
// requesters. Round-robin selection with a request lock, plus an in-order
// ID FIFO that steers each response back to the requester that issued it.
module core_req_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,

    output logic                    err_o,
    output logic                    idle_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Lock state doubles as the locked requester ID.
    typedef enum logic [1:0] {
        ARB_FREE    = 2'd0,
        ARB_LOCK_M0 = 2'd1,
        ARB_LOCK_M1 = 2'd2
    } arb_state_t;

    arb_state_t state_reg, state_next;
    logic       rr_ptr_reg;     // requester favoured on a tie
    logic       err_reg;

    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic             id_mem [MAX_OUTSTANDING];

    logic                  sel;
    logic                  handshake;
    logic                  fifo_full, fifo_empty;
    logic                  store, pop, bypass, stray, resp_fwd;
    logic                  head_id;
    logic [1:0]            req_vec, gnt_vec, rvalid_vec;
    logic [ADDR_WIDTH-1:0] addr_arr  [2];
    logic                  we_arr    [2];
    logic [BE_W-1:0]       be_arr    [2];
    logic [DATA_WIDTH-1:0] wdata_arr [2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign req_vec      = {m1_req_i, m0_req_i};
    assign addr_arr[0]  = m0_addr_i;
    assign addr_arr[1]  = m1_addr_i;
    assign we_arr[0]    = m0_we_i;
    assign we_arr[1]    = m1_we_i;
    assign be_arr[0]    = m0_be_i;
    assign be_arr[1]    = m1_be_i;
    assign wdata_arr[0] = m0_wdata_i;
    assign wdata_arr[1] = m1_wdata_i;

    // Requester selection: lock wins, then a lone requester, then the pointer.
    always_comb begin
        sel = rr_ptr_reg;
        case (state_reg)
            ARB_LOCK_M0: sel = 1'b0;
            ARB_LOCK_M1: sel = 1'b1;
            default: begin
                if (m0_req_i && !m1_req_i) begin
                    sel = 1'b0;
                end else if (m1_req_i && !m0_req_i) begin
                    sel = 1'b1;
                end
            end
        endcase
    end

    assign fifo_full  = (count_reg == CNT_MAX);
    assign fifo_empty = (count_reg == '0);

    // Downstream request is held off while in reset and while the ID FIFO is full.
    assign data_req_o   = req_vec[sel] & ~fifo_full & ~rst_i;
    assign data_addr_o  = addr_arr[sel];
    assign data_we_o    = we_arr[sel];
    assign data_be_o    = be_arr[sel];
    assign data_wdata_o = wdata_arr[sel];
    assign handshake    = data_req_o & data_gnt_i;

    // A response arriving together with a grant into an empty FIFO belongs to
    // that very grant, so it bypasses storage entirely.
    assign bypass   = handshake & data_rvalid_i & fifo_empty;
    assign store    = handshake & ~bypass;
    assign pop      = data_rvalid_i & ~fifo_empty;
    assign stray    = data_rvalid_i & fifo_empty & ~handshake;
    assign resp_fwd = data_rvalid_i & (~fifo_empty | handshake);
    assign head_id  = fifo_empty ? sel : id_mem[rd_ptr_reg];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_vec[gi]    = handshake & (sel == 1'(gi));
        assign rvalid_vec[gi] = resp_fwd & (head_id == 1'(gi));
    end

    assign m0_gnt_o    = gnt_vec[0];
    assign m1_gnt_o    = gnt_vec[1];
    assign m0_rvalid_o = rvalid_vec[0];
    assign m1_rvalid_o = rvalid_vec[1];
    assign m0_rdata_o  = data_rdata_i;
    assign m1_rdata_o  = data_rdata_i;
    assign err_o       = err_reg;
    assign idle_o      = fifo_empty & (state_reg == ARB_FREE);

    // Lock FSM next state: lock on an ungranted request, release on handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_FREE: begin
                if (data_req_o && !data_gnt_i) begin
                    state_next = sel ? ARB_LOCK_M1 : ARB_LOCK_M0;
                end
            end
            ARB_LOCK_M0, ARB_LOCK_M1: begin
                if (handshake) begin
                    state_next = ARB_FREE;
                end
            end
            default: state_next = ARB_FREE;
        endcase
    end

    // Lock state, round-robin pointer and sticky error register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ARB_FREE;
            rr_ptr_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                rr_ptr_reg <= ~sel;
            end
            if (stray) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Outstanding count follows stores and pops; a store-plus-pop cancels.
    always_comb begin
        count_next = count_reg;
        if (store && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !store) begin
            count_next = count_reg - 1'b1;
        end
    end

    // ID FIFO pointers and count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (store) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // ID storage; contents are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (store) begin
            id_mem[wr_ptr_reg] <= sel;
        end
    end

endmodule

// File: tb/tb_core_req_arbiter.sv
// Testbench for core_req_arbiter: directed scenarios plus a randomized run,
// all checked every cycle against a queue-based reference model.
module tb_core_req_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
    logic          m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]    m0_be_i = '0, m1_be_i = '0;
    logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          data_req_o;
    logic          data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
    logic [AW-1:0] data_addr_o;
    logic          data_we_o;
    logic [3:0]    data_be_o;
    logic [DW-1:0] data_wdata_o;
    logic [DW-1:0] data_rdata_i = '0;
    logic          err_o, idle_o;

    core_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
        .err_o(err_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding requester IDs in issue order,
    // the favoured requester, the locked requester (-1 = none), sticky error.
    int q[$];
    int favour  = 0;
    int lock_id = -1;
    bit err_m   = 1'b0;

    // Per-cycle model results.
    int           e_sel;
    bit           e_req, e_hs;
    logic [139:0] e_vec;

    task automatic model_reset();
        q.delete();
        favour  = 0;
        lock_id = -1;
        err_m   = 1'b0;
    endtask

    // Predict all outputs from the current inputs and model state.
    task automatic model_eval();
        int owner;
        if (rst_i) model_reset();
        if (lock_id >= 0)                e_sel = lock_id;
        else if (m0_req_i && !m1_req_i)  e_sel = 0;
        else if (m1_req_i && !m0_req_i)  e_sel = 1;
        else                             e_sel = favour;
        e_req = !rst_i && ((e_sel == 0) ? m0_req_i : m1_req_i) && (q.size() < MAXO);
        e_hs  = e_req && data_gnt_i;
        owner = -1;
        if (data_rvalid_i && !rst_i) begin
            if (q.size() > 0) owner = q[0];
            else if (e_hs)    owner = e_sel;
        end
        e_vec = {e_hs && (e_sel == 0), e_hs && (e_sel == 1), owner == 0, owner == 1,
                 e_req, err_m, (q.size() == 0) && (lock_id < 0),
                 e_req ? ((e_sel == 0) ? {m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i}
                                       : {m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i}) : 69'b0,
                 data_rdata_i, data_rdata_i};
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_commit();
        bit was_empty;
        if (rst_i) begin
            model_reset();
            return;
        end
        was_empty = (q.size() == 0);
        if (data_rvalid_i) begin
            if (!was_empty) void'(q.pop_front());
            else if (!e_hs) err_m = 1'b1;
        end
        if (e_hs) begin
            if (!(data_rvalid_i && was_empty)) q.push_back(e_sel);
            favour  = 1 - e_sel;
            lock_id = -1;
        end else if (e_req) begin
            lock_id = e_sel;
        end
    endtask

    function automatic logic [139:0] dut_vec();
        return {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, data_req_o, err_o, idle_o,
                data_req_o ? {data_addr_o, data_we_o, data_be_o, data_wdata_o} : 69'b0,
                m0_rdata_o, m1_rdata_o};
    endfunction

    // Apply {rst, m0_req, m1_req, gnt, rvalid} with fresh random payload.
    task automatic drive(input logic [4:0] s);
        {rst_i, m0_req_i, m1_req_i, data_gnt_i, data_rvalid_i} = s;
        m0_we_i      = 1'($urandom);
        m1_we_i      = 1'($urandom);
        m0_be_i      = 4'($urandom);
        m1_be_i      = 4'($urandom);
        m0_wdata_i   = $urandom;
        m1_wdata_i   = $urandom;
        data_rdata_i = $urandom;
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] tbl [3] = '{5'b11110, 5'b11101, 5'b00000};
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL reset cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            checks++;
            if (i < 2 && {data_req_o, m0_gnt_o, m1_gnt_o, idle_o, err_o} !== 5'b00010) begin
                errors++;
                $display("FAIL reset_outs cyc %0d got %b want 00010", i,
                         {data_req_o, m0_gnt_o, m1_gnt_o, idle_o, err_o});
            end
            $display("reset cyc %0d req=%b idle=%b err=%b", i, data_req_o, idle_o, err_o);
            advance();
        end
    endtask

    task automatic test_single();
        logic [4:0] tbl [3] = '{5'b01010, 5'b00000, 5'b00001};
        m0_addr_i = 32'h0000_1000;
        m1_addr_i = 32'h0000_2000;
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            m0_we_i = 1'b0;
            if (i == 2) data_rdata_i = 32'hDEAD_BEEF;
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL single cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            if (i == 0) begin
                checks++;
                if ({m0_gnt_o, data_addr_o} !== {1'b1, 32'h0000_1000}) begin
                    errors++;
                    $display("FAIL single_gnt got %b/%h want 1/00001000", m0_gnt_o, data_addr_o);
                end
            end
            if (i == 2) begin
                checks++;
                if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("FAIL single_rvalid got %b%b/%h want 10/deadbeef",
                             m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
                end
            end
            $display("single cyc %0d gnt0=%b rv0=%b rv1=%b rdata=%h", i, m0_gnt_o,
                     m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
            advance();
        end
    endtask

    task automatic test_alternate();
        int prev = -1;
        int gid;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive({4'b0111, (i > 0) ? 1'b1 : 1'b0});
            else       drive(5'b00001);
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL alt cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            gid = m1_gnt_o ? 1 : 0;
            if (i < 8) begin
                checks++;
                if ((m0_gnt_o ^ m1_gnt_o) !== 1'b1 || (prev >= 0 && gid == prev)) begin
                    errors++;
                    $display("FAIL alt_order cyc %0d got gnt=%b%b want other than %0d",
                             i, m1_gnt_o, m0_gnt_o, prev);
                end
            end
            if (i > 0) begin
                checks++;
                if ({m1_rvalid_o, m0_rvalid_o} !== ((prev == 1) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL alt_rvalid cyc %0d got %b%b want owner %0d",
                             i, m1_rvalid_o, m0_rvalid_o, prev);
                end
            end
            $display("alt cyc %0d gnt=%b%b rvalid=%b%b", i, m1_gnt_o, m0_gnt_o,
                     m1_rvalid_o, m0_rvalid_o);
            prev = gid;
            advance();
        end
    endtask

    task automatic test_lock();
        logic [4:0] tbl [8] = '{5'b00100, 5'b00100, 5'b00100, 5'b01100,
                                5'b01110, 5'b01110, 5'b00001, 5'b00001};
        m0_addr_i = 32'hA000_0000;
        m1_addr_i = 32'hA111_1111;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL lock cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            if (i <= 4) begin
                checks++;
                if (data_addr_o !== 32'hA111_1111) begin
                    errors++;
                    $display("FAIL lock_addr cyc %0d got %h want a1111111", i, data_addr_o);
                end
            end
            if (i == 4 || i == 5) begin
                checks++;
                if ({m1_gnt_o, m0_gnt_o} !== ((i == 4) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL lock_gnt cyc %0d got %b%b", i, m1_gnt_o, m0_gnt_o);
                end
            end
            $display("lock cyc %0d addr=%h gnt=%b%b", i, data_addr_o, m1_gnt_o, m0_gnt_o);
            advance();
        end
    endtask

    task automatic test_full();
        logic [4:0] tbl [10] = '{5'b01010, 5'b01010, 5'b01010, 5'b01011, 5'b01010,
                                 5'b01011, 5'b01011, 5'b00000, 5'b00001, 5'b00000};
        m0_addr_i = 32'h0000_3000;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL full cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            if (i == 2 || i == 3 || i == 5) begin
                checks++;
                if (data_req_o !== 1'b0) begin
                    errors++;
                    $display("FAIL full_block cyc %0d got req=%b want 0", i, data_req_o);
                end
            end
            if (i == 6) begin
                checks++;
                if ({m0_gnt_o, m0_rvalid_o} !== 2'b11) begin
                    errors++;
                    $display("FAIL full_pushpop got %b want 11", {m0_gnt_o, m0_rvalid_o});
                end
            end
            if (i == 7 || i == 9) begin
                checks++;
                if (idle_o !== ((i == 9) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL full_idle cyc %0d got %b", i, idle_o);
                end
            end
            $display("full cyc %0d req=%b gnt=%b rv=%b idle=%b", i, data_req_o, m0_gnt_o,
                     m0_rvalid_o, idle_o);
            advance();
        end
    endtask

    task automatic test_zero_latency();
        logic [4:0] tbl [2] = '{5'b00111, 5'b00000};
        for (int i = 0; i < 2; i++) begin
            drive(tbl[i]);
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL zlat cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            checks++;
            if ((i == 0 && {m1_gnt_o, m1_rvalid_o} !== 2'b11) ||
                (i == 1 && {err_o, idle_o} !== 2'b01)) begin
                errors++;
                $display("FAIL zlat_chk cyc %0d got gnt1=%b rv1=%b err=%b idle=%b",
                         i, m1_gnt_o, m1_rvalid_o, err_o, idle_o);
            end
            $display("zlat cyc %0d gnt1=%b rv1=%b err=%b", i, m1_gnt_o, m1_rvalid_o, err_o);
            advance();
        end
    endtask

    task automatic test_random();
        bit r0, r1, g, rv, rs;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 63) == 0);
            r0 = (i < 394) && ($urandom_range(0, 3) != 0);
            r1 = (i < 394) && ($urandom_range(0, 3) != 0);
            g  = 1'($urandom);
            rv = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            m0_addr_i = $urandom;
            m1_addr_i = $urandom;
            drive({rs, r0, r1, g, rv});
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL rand cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            $display("rand cyc %0d in=%b%b%b%b%b req=%b gnt=%b%b rv=%b%b", i, rs, r0, r1, g,
                     rv, data_req_o, m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o);
            advance();
        end
    endtask

    task automatic test_stray();
        logic [4:0] tbl [5] = '{5'b10000, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i]);
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL stray cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            if (i >= 1) begin
                checks++;
                if ({m0_rvalid_o, m1_rvalid_o, err_o} !== {2'b00, (i >= 2) ? 1'b1 : 1'b0}) begin
                    errors++;
                    $display("FAIL stray_err cyc %0d got rv=%b%b err=%b", i,
                             m1_rvalid_o, m0_rvalid_o, err_o);
                end
            end
            $display("stray cyc %0d rv=%b%b err=%b", i, m1_rvalid_o, m0_rvalid_o, err_o);
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] tbl [7] = '{5'b01010, 5'b11010, 5'b00000, 5'b01010,
                                5'b00001, 5'b00001, 5'b00000};
        m0_addr_i = 32'h0000_4000;
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            if (i == 4) data_rdata_i = 32'hCAFE_0001;
            #1; model_eval();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL rstmid cyc %0d got %h want %h", i, dut_vec(), e_vec);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if ({data_req_o, m0_gnt_o, idle_o, err_o} !== 4'b0010) begin
                    errors++;
                    $display("FAIL rstmid_clear cyc %0d got %b want 0010", i,
                             {data_req_o, m0_gnt_o, idle_o, err_o});
                end
            end
            if (i == 4) begin
                checks++;
                if ({m0_rvalid_o, m0_rdata_o, err_o} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
                    errors++;
                    $display("FAIL rstmid_resp got %b/%h/%b want 1/cafe0001/0",
                             m0_rvalid_o, m0_rdata_o, err_o);
                end
            end
            if (i == 6) begin
                checks++;
                if (err_o !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_stray got err=%b want 1", err_o);
                end
            end
            $display("rstmid cyc %0d req=%b idle=%b err=%b rv0=%b", i, data_req_o, idle_o,
                     err_o, m0_rvalid_o);
            advance();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_zero_latency();
        test_random();
        test_stray();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
